conga_note_scheduler: RTL and testbench

- Downstream consumer of the conga song-position counter's 16-bit `count`.
- Walks a fixed built-in note chart and fires each note once `count` reaches its timestamp.
- Queues fired notes in a small show-ahead FIFO and presents them to the lane/draw stage over a valid/ready handshake.
- Rewinds to the chart start whenever the song is restarted (same `go` pulse that clears the counter).

---
 rtl/conga_note_scheduler.sv | 128 ++++++++++++
 tb/tb_conga_note_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/conga_note_scheduler.sv
// Note-chart scheduler: fires built-in chart entries as the song position
// reaches them and hands them downstream through a small show-ahead FIFO.
module conga_note_scheduler #(
   parameter int unsigned NUM_NOTES  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] count,
   input  logic        restart,
   input  logic        note_ready,
   output logic        note_valid,
   output logic [1:0]  note_lane,
   output logic [15:0] note_time,
   output logic [3:0]  level,
   output logic        done
);

   localparam int unsigned IW = 4;
   localparam int unsigned LW = 4;
   localparam int unsigned TW = 16;
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef struct packed {
      logic [1:0]    lane;
      logic [TW-1:0] tstamp;
   } note_t;

   // Fixed chart; last entry sits at the counter's saturation value.
   function automatic note_t chart(input logic [IW-1:0] i);
      note_t n;
      n = '0;
      case (i)
         4'd0:    n = {2'd0, 16'd16};
         4'd1:    n = {2'd1, 16'd32};
         4'd2:    n = {2'd2, 16'd48};
         4'd3:    n = {2'd3, 16'd48};
         4'd4:    n = {2'd0, 16'd64};
         4'd5:    n = {2'd1, 16'd96};
         4'd6:    n = {2'd2, 16'd96};
         4'd7:    n = {2'd3, 16'd39648};
         default: n = '0;
      endcase
      return n;
   endfunction

   logic [IW-1:0] idx, idx_n;
   logic [PW-1:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
   logic [LW-1:0] level_n;
   logic          valid_n, done_n;
   note_t         head_n;
   note_t         cur_c;
   logic          pop_c, push_ok_c, fire_c;
   note_t         mem [FIFO_DEPTH];

   // Fire / pop decisions and next-state of pointers, occupancy and head.
   always_comb begin
      cur_c     = chart(idx);
      pop_c     = note_valid && note_ready;
      push_ok_c = (level < LW'(FIFO_DEPTH)) || pop_c;
      fire_c    = (idx < IW'(NUM_NOTES)) && (count >= cur_c.tstamp) && push_ok_c && !restart;

      idx_n    = idx;
      rd_ptr_n = rd_ptr;
      wr_ptr_n = wr_ptr;
      level_n  = level;
      valid_n  = note_valid;
      head_n   = {note_lane, note_time};
      done_n   = done;

      if (restart) begin
         idx_n    = '0;
         rd_ptr_n = '0;
         wr_ptr_n = '0;
         level_n  = '0;
         valid_n  = 1'b0;
         done_n   = 1'b0;
      end else begin
         if (fire_c) begin
            idx_n    = idx + IW'(1);
            wr_ptr_n = wr_ptr + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_n = rd_ptr + PW'(1);
         end
         level_n = level + LW'(fire_c) - LW'(pop_c);
         valid_n = (level_n != '0);
         // New head is the entry being written when the FIFO was effectively empty.
         if (level_n != '0) begin
            head_n = (fire_c && (rd_ptr_n == wr_ptr)) ? cur_c : mem[rd_ptr_n];
         end
         done_n = done || ((idx_n == IW'(NUM_NOTES)) && (level_n == '0));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         note_valid <= 1'b0;
         note_lane  <= '0;
         note_time  <= '0;
         done       <= 1'b0;
      end else begin
         idx        <= idx_n;
         rd_ptr     <= rd_ptr_n;
         wr_ptr     <= wr_ptr_n;
         level      <= level_n;
         note_valid <= valid_n;
         note_lane  <= head_n.lane;
         note_time  <= head_n.tstamp;
         done       <= done_n;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (fire_c) begin
         mem[wr_ptr] <= cur_c;
      end
   end

endmodule

// File: tb/tb_conga_note_scheduler.sv
// Bench for conga_note_scheduler: directed song phases plus random traffic,
// compared each cycle against a queue-based model of the note chart.
module tb_conga_note_scheduler;

   logic        clk;
   logic        resetn;
   logic [15:0] count;
   logic        restart;
   logic        note_ready;
   logic        note_valid;
   logic [1:0]  note_lane;
   logic [15:0] note_time;
   logic [3:0]  level;
   logic        done;

   int checks   = 0;
   int failures = 0;

   int unsigned chart_t [8] = '{16, 32, 48, 48, 64, 96, 96, 39648};
   int unsigned chart_l [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   int unsigned m_idx;
   int unsigned q [$];
   int unsigned e_lane;
   int unsigned e_time;
   bit          m_done;

   conga_note_scheduler dut (
      .clk        (clk),
      .resetn     (resetn),
      .count      (count),
      .restart    (restart),
      .note_ready (note_ready),
      .note_valid (note_valid),
      .note_lane  (note_lane),
      .note_time  (note_time),
      .level      (level),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_idx  = 0;
      q.delete();
      e_lane = 0;
      e_time = 0;
      m_done = 1'b0;
   endtask

   // One clock edge of the chart: pop the head if taken, fire the next note if due and room.
   task automatic model_step();
      bit do_pop;
      bit do_fire;
      if (restart) begin
         m_idx = 0;
         q.delete();
         m_done = 1'b0;
      end else begin
         do_pop  = (q.size() > 0) && note_ready;
         do_fire = (m_idx < 8) && (int'(count) >= int'(chart_t[m_idx]))
                   && ((q.size() < 4) || do_pop);
         if (do_pop) void'(q.pop_front());
         if (do_fire) begin
            q.push_back(m_idx);
            m_idx++;
         end
         if (m_idx == 8 && q.size() == 0) m_done = 1'b1;
      end
      if (q.size() > 0) begin
         e_lane = chart_l[q[0]];
         e_time = chart_t[q[0]];
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, "_valid"}, 32'(note_valid), (q.size() > 0) ? 32'd1 : 32'd0);
      chk({ph, "_lane"},  32'(note_lane),  32'(e_lane));
      chk({ph, "_time"},  32'(note_time),  32'(e_time));
      chk({ph, "_level"}, 32'(level),      32'(q.size()));
      chk({ph, "_done"},  32'(done),       32'(m_done));
   endtask

   task automatic tick(input string ph);
      @(posedge clk);
      model_step();
      #1;
      check_all(ph);
   endtask

   task automatic do_restart(input string ph);
      restart = 1'b1;
      tick(ph);
      restart = 1'b0;
      count   = 16'd0;
   endtask

   task automatic ramp(input int unsigned to, input string ph);
      while (int'(count) < int'(to)) begin
         count = count + 16'd1;
         tick(ph);
      end
   endtask

   initial begin
      resetn     = 1'b0;
      count      = 16'd0;
      restart    = 1'b0;
      note_ready = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      resetn = 1'b1;
      #2;

      // Sequential fire and shared timestamps
      do_restart("rst0");
      note_ready = 1'b1;
      tick("seq");
      ramp(40, "seq");
      ramp(60, "shared");
      repeat (3) tick("shared");

      // Backpressure: four notes queue, the rest stall
      do_restart("rst1");
      note_ready = 1'b0;
      ramp(100, "bp");
      chk("bp_level_full", 32'(level), 32'd4);
      // Single ready pulse while full: simultaneous pop and push
      note_ready = 1'b1;
      tick("pushpop");
      note_ready = 1'b0;
      tick("pushpop");
      chk("pushpop_level", 32'(level), 32'd4);
      chk("pushpop_head", 32'(note_time), 32'd32);
      note_ready = 1'b1;
      repeat (8) tick("drain");

      // Completion at the counter's final value
      ramp(39648, "final");
      repeat (4) tick("donehold");
      chk("done_set", 32'(done), 32'd1);

      // Restart mid-song with two notes queued
      do_restart("rst2");
      note_ready = 1'b1;
      ramp(47, "mid");
      note_ready = 1'b0;
      ramp(60, "mid");
      chk("mid_level2", 32'(level), 32'd2);
      do_restart("rst3");
      chk("rst3_level", 32'(level), 32'd0);
      chk("rst3_valid", 32'(note_valid), 32'd0);
      note_ready = 1'b1;
      ramp(20, "reramp");

      // Random count advance, pauses, ready and occasional restarts
      do_restart("rst4");
      for (int i = 0; i < 600; i++) begin
         note_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 79) == 0) begin
            do_restart("rnd_rst");
         end else begin
            if ($urandom_range(0, 3) != 0) count = count + 16'd1;
            tick("rnd");
         end
      end

      // Asynchronous reset between edges
      note_ready = 1'b0;
      count = 16'd200;
      tick("pre_arst");
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      #3;
      resetn = 1'b1;
      do_restart("post_arst");
      note_ready = 1'b1;
      ramp(20, "post_arst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
